seq_restoring_divider: RTL



---
 rtl/seq_restoring_divider.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN: zero divisor short-circuits to DONE and raises div_by_zero.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH+1:0] SUM_ONE = {{(WIDTH+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] d_q, q_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic [WIDTH-1:0] r_d, q_d;
    logic             unused_sum_bit;

    // Trial subtract R - {0,D} as R + ~{0,D} + 1; carry-out set means no borrow.
    always_comb begin
        r_sh      = {r_q, q_q[WIDTH-1]};
        sum       = {1'b0, r_sh} + {1'b0, ~{1'b0, d_q}} + SUM_ONE;
        no_borrow = sum[WIDTH+1];
        r_d       = no_borrow ? sum[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_d       = {q_q[WIDTH-2:0], no_borrow};
    end

    // A successful trial always leaves a result below D, so bit WIDTH is zero.
    assign unused_sum_bit = sum[WIDTH];

`ifdef DIV_ZERO_CHECK_EN
    logic dz_q;
    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        d_q    <= divisor;
                        q_q    <= dividend;
                        r_q    <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            quo_q   <= '1;
                            rem_q   <= dividend;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= S_RUN;
                        end
`else
                        state_q <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        quo_q   <= q_d;
                        rem_q   <= r_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
